hex_display_scheduler: RTL and testbench

Time-shares the six-digit seven-segment display of the pathfinding accelerator between several on-chip status sources (search progress, node counters, debug). Each requester offers a 24-bit value (six hex nibbles, digit 0 in bits [3:0]). The scheduler grants the display round-robin with a guaranteed minimum dwell, so every value stays readable for a fixed time. It drives the nibble inputs of the existing per-digit seven-segment decoders.

---
 rtl/hex_display_scheduler_if.sv | 24 ++
 rtl/hex_display_scheduler.sv | 122 ++++++++++++
 tb/tb_hex_display_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scheduler_if.sv
// Display-scheduler bus: requester request/data lanes and the registered
// display-side outputs. The master side is the requester/observer, the slave side is the scheduler.
interface hex_display_scheduler_if #(
    parameter int N_REQ = 3,
    parameter int OWN_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req;
    logic [24*N_REQ-1:0] data;
    logic [N_REQ-1:0]    ack;
    logic [23:0]         disp_data;
    logic                disp_valid;
    logic [OWN_W-1:0]    owner;
    logic                busy;

    modport master (
        output req, data,
        input  ack, disp_data, disp_valid, owner, busy
    );

    modport slave (
        input  req, data,
        output ack, disp_data, disp_valid, owner, busy
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Round-robin time-sharing of the six-digit hex display between requesters,
// with a guaranteed minimum dwell per grant and in-dwell refresh by the owner.
module hex_display_scheduler #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    hex_display_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int OWN_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWN_W-1:0] LAST_RST  = OWN_W'(N_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OWN_W-1:0] last_q, last_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [23:0]      disp_data_q, disp_data_d;
    logic             disp_valid_q, disp_valid_d;
    logic [N_REQ-1:0] ack_q, ack_d;

    logic [23:0]      data_arr [N_REQ];
    logic             win_found;
    logic [OWN_W-1:0] win_idx;
    logic             do_grant;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_arr[gi] = bus.data[24*gi +: 24];
        end
    endgenerate

    // Index of the requester 'off' places after 'base', wrapping modulo N_REQ.
    function automatic logic [OWN_W-1:0] wrap_idx(input logic [OWN_W-1:0] base, input int off);
        int s;
        s = int'(base) + 1 + off;
        if (s >= N_REQ) s -= N_REQ;
        return OWN_W'(s);
    endfunction

    // last_q equals owner_q whenever in HOLD, so one scan origin serves both cases.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && bus.req[wrap_idx(last_q, i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(last_q, i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_d       = last_q;
        owner_d      = owner_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        ack_d        = '0;
        do_grant     = 1'b0;

        case (state_q)
            IDLE: do_grant = win_found;
            HOLD: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                    // Owner refresh updates the shown value but never restarts the dwell.
                    if (bus.req[owner_q]) begin
                        disp_data_d    = data_arr[owner_q];
                        ack_d[owner_q] = 1'b1;
                    end
                end else if (win_found) begin
                    do_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (do_grant) begin
            state_d        = HOLD;
            count_d        = HOLD_LOAD;
            last_d         = win_idx;
            owner_d        = win_idx;
            disp_data_d    = data_arr[win_idx];
            disp_valid_d   = 1'b1;
            ack_d          = '0;
            ack_d[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            last_q       <= LAST_RST;
            owner_q      <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q == HOLD);
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler (N_REQ=3, HOLD_CYCLES=4): table of per-edge
// vectors, ack scoreboard, and hand sequences around asynchronous reset.
module tb_hex_display_scheduler;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    hex_display_scheduler_if #(.N_REQ(3)) bus();

    hex_display_scheduler #(.N_REQ(3), .HOLD_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] d0, d1, d2;
        logic [2:0]  ack;
        logic [23:0] disp;
        logic [1:0]  own;
        logic        valid;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [2:0]  ack;
        logic [23:0] disp;
        logic [1:0]  own;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [2:0] ea, input logic [23:0] ed,
                       input logic [1:0] eo, input logic ev, input logic eb);
        vec_t v;
        v.req = r; v.d0 = a; v.d1 = b; v.d2 = c;
        v.ack = ea; v.disp = ed; v.own = eo; v.valid = ev; v.busy = eb;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [23:0] d, input logic [1:0] o);
        sb_t e;
        e.ack = a; e.disp = d; e.own = o;
        sb.push_back(e);
    endtask

    task automatic drive_step(input logic [2:0] r, input logic [23:0] a,
                              input logic [23:0] b, input logic [23:0] c);
        bus.req  = r;
        bus.data = {c, b, a};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp"},  32'(bus.disp_data),  32'h0);
        chk({tag, "_valid"}, 32'(bus.disp_valid), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),       32'h0);
        chk({tag, "_owner"}, 32'(bus.owner),      32'h0);
        chk({tag, "_ack"},   32'(bus.ack),        32'h0);
    endtask

    // Scoreboard: every ack pulse must be one-hot and match the oldest expected grant/refresh.
    always @(posedge clk) begin
        #2;
        if (bus.ack != 3'b000) begin
            chk("sb_onehot", 32'($onehot(bus.ack)), 32'h1);
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 32'(bus.ack), 32'h0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_ack",   32'(bus.ack),       32'(e.ack));
                chk("sb_disp",  32'(bus.disp_data), 32'(e.disp));
                chk("sb_owner", 32'(bus.owner),     32'(e.own));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int o;
        // Idle after reset release.
        for (int n = 0; n < 10; n++) add(3'b000, 24'h0, 24'h0, 24'h0, 3'b000, 24'h0, 2'd0, 1'b0, 1'b0);
        // Three-way contention: owner rotates 0,1,2,0,1 every 4 edges, owner refreshes in between.
        for (int n = 0; n < 20; n++) begin
            o = (n / 4) % 3;
            add(3'b111, 24'h0, 24'h1, 24'h2, 3'(1 << o), 24'(o), 2'(o), 1'b1, 1'b1);
        end
        // Owner 1 refresh mid-dwell; requester 0 waits and wins exactly 4 edges after the grant.
        add(3'b010, 24'h0C0FFE, 24'hAAAAAA, 24'h2, 3'b010, 24'hAAAAAA, 2'd1, 1'b1, 1'b1);
        add(3'b011, 24'h0C0FFE, 24'hAAAAAA, 24'h2, 3'b010, 24'hAAAAAA, 2'd1, 1'b1, 1'b1);
        add(3'b011, 24'h0C0FFE, 24'hBBBBBB, 24'h2, 3'b010, 24'hBBBBBB, 2'd1, 1'b1, 1'b1);
        add(3'b011, 24'h0C0FFE, 24'hBBBBBB, 24'h2, 3'b010, 24'hBBBBBB, 2'd1, 1'b1, 1'b1);
        add(3'b011, 24'h0C0FFE, 24'hBBBBBB, 24'h2, 3'b001, 24'h0C0FFE, 2'd0, 1'b1, 1'b1);
        // All requests dropped: dwell runs out, then idle with retained value.
        for (int n = 0; n < 3; n++) add(3'b000, 24'h0C0FFE, 24'hBBBBBB, 24'h2, 3'b000, 24'h0C0FFE, 2'd0, 1'b1, 1'b1);
        for (int n = 0; n < 2; n++) add(3'b000, 24'h0C0FFE, 24'hBBBBBB, 24'h2, 3'b000, 24'h0C0FFE, 2'd0, 1'b1, 1'b0);
        add(3'b100, 24'h0C0FFE, 24'hBBBBBB, 24'h654321, 3'b100, 24'h654321, 2'd2, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) add(3'b000, 24'h0C0FFE, 24'hBBBBBB, 24'h654321, 3'b000, 24'h654321, 2'd2, 1'b1, 1'b1);
        add(3'b000, 24'h0C0FFE, 24'hBBBBBB, 24'h654321, 3'b000, 24'h654321, 2'd2, 1'b1, 1'b0);
        // Single grant to requester 0.
        add(3'b001, 24'h123456, 24'hBBBBBB, 24'h654321, 3'b001, 24'h123456, 2'd0, 1'b1, 1'b1);

        rst_n    = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].ack != 3'b000) push_exp(vecs[i].ack, vecs[i].disp, vecs[i].own);
            drive_step(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            $display("[TB] row %0d req=%b ack=%b owner=%0d disp=%06h valid=%b busy=%b",
                     i, vecs[i].req, bus.ack, bus.owner, bus.disp_data, bus.disp_valid, bus.busy);
            chk($sformatf("row%0d_ack", i),   32'(bus.ack),        32'(vecs[i].ack));
            chk($sformatf("row%0d_disp", i),  32'(bus.disp_data),  32'(vecs[i].disp));
            chk($sformatf("row%0d_owner", i), 32'(bus.owner),      32'(vecs[i].own));
            chk($sformatf("row%0d_valid", i), 32'(bus.disp_valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d_busy", i),  32'(bus.busy),       32'(vecs[i].busy));
        end

        // Mid-simulation async reset while busy, no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset mid-dwell owner=%0d disp=%06h busy=%b", bus.owner, bus.disp_data, bus.busy);
        chk_all_zero("async1");
        @(negedge clk);
        rst_n = 1'b1;

        // Grant requester 2, one more edge leaves count at 2, then async reset.
        push_exp(3'b100, 24'hABCDEF, 2'd2);
        drive_step(3'b100, 24'h0, 24'h0, 24'hABCDEF);
        $display("[TB] grant req=100 ack=%b owner=%0d disp=%06h", bus.ack, bus.owner, bus.disp_data);
        chk("r6_grant_owner", 32'(bus.owner), 32'd2);
        chk("r6_grant_busy",  32'(bus.busy),  32'd1);
        push_exp(3'b100, 24'hABCDEF, 2'd2);
        drive_step(3'b100, 24'h0, 24'h0, 24'hABCDEF);
        $display("[TB] refresh req=100 ack=%b owner=%0d disp=%06h", bus.ack, bus.owner, bus.disp_data);
        chk("r6_refresh_ack", 32'(bus.ack), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset count=2 owner=%0d disp=%06h busy=%b", bus.owner, bus.disp_data, bus.busy);
        chk_all_zero("async2");
        @(negedge clk);
        rst_n = 1'b1;

        push_exp(3'b001, 24'h111111, 2'd0);
        drive_step(3'b111, 24'h111111, 24'h222222, 24'h333333);
        $display("[TB] post-reset req=111 ack=%b owner=%0d disp=%06h", bus.ack, bus.owner, bus.disp_data);
        chk("r6_first_owner", 32'(bus.owner),     32'd0);
        chk("r6_first_ack",   32'(bus.ack),       32'h1);
        chk("r6_first_disp",  32'(bus.disp_data), 32'h111111);

        bus.req = '0;
        #5;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
